hack_loader: RTL and testbench

HACK_LOADER -- requirements
Module: hack_loader

---
 rtl/hack_pkg.sv | 23 ++
 rtl/hack_loader_byte_pair.sv | 48 ++++
 rtl/hack_loader.sv | 176 +++++++++++++++++
 tb/tb_hack_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: types and constants shared by the HACK instruction-ROM loader.
// Optional feature macro: HACK_LOADER_CHECKSUM_EN (adds the CHK_HI/CHK_LO states).
package hack_pkg;

  localparam int WORD_W         = 16;
  localparam int ADDR_W_DEFAULT = 15;

`ifdef HACK_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DAT_HI, DAT_LO, CHK_HI, CHK_LO, RUN, ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, DAT_HI, DAT_LO, RUN, ERR
  } state_e;
`endif

  // Every state except the two terminal ones is still consuming bytes.
  function automatic logic is_loading(input state_e s);
    return (s != RUN) && (s != ERR);
  endfunction

endpackage

// File: rtl/hack_loader_byte_pair.sv
// byte_pair: holds the high byte of a big-endian pair and, when the low byte
// arrives, registers the assembled word together with a one-cycle strobe.
// The registered word stays put between strobes, so it can drive the ROM
// write-data bus directly.
module byte_pair
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [7:0]        byte_i,
  output logic [7:0]        hi_o,
  output logic [WORD_W-1:0] word_o,
  output logic              vld_o
);

  logic [7:0]        hi_q;
  logic [WORD_W-1:0] word_q;
  logic              vld_q;

  // Capture the high byte of the current pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
    end else if (hi_we_i) begin
      hi_q <= byte_i;
    end
  end

  // Assemble {hi,lo} on the low byte and strobe valid for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= lo_we_i;
      if (lo_we_i) begin
        word_q <= {hi_q, byte_i};
      end
    end
  end

  assign hi_o   = hi_q;
  assign word_o = word_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/hack_loader.sv
// hack_loader: receives a byte stream {N_hi, N_lo, w0_hi, w0_lo, ...}, writes
// the N words into the instruction ROM at addresses 0..N-1, then releases the
// CPU from reset. An over-long header parks the loader in a sticky error state.
// Optional feature macro: HACK_LOADER_CHECKSUM_EN -- a 16-bit wrapping sum of
// the written words is compared against two trailing checksum bytes.
module hack_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_nrst,
  output logic              done,
  output logic              err
);

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam state_e POST_DATA = CHK_HI;
`else
  localparam state_e POST_DATA = RUN;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WORD_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_q;
  logic              done_q;
  logic              err_q;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;
`endif

  logic              accept;
  logic              hi_we;
  logic              lo_we;
  logic [7:0]        pair_hi;
  logic [WORD_W-1:0] pair_word;
  logic              pair_vld;
  logic [WORD_W-1:0] pair_w;
  logic              last_word;

  assign accept    = in_valid && ready_q;
  // Word formed by the latched high byte and the byte on the bus right now.
  assign pair_w    = {pair_hi, in_data};
  assign last_word = ((32'(idx_q) + 32'd1) == 32'(cnt_q));

  byte_pair u_pair (
    .clk     (clk),
    .rst     (rst),
    .hi_we_i (hi_we),
    .lo_we_i (lo_we),
    .byte_i  (in_data),
    .hi_o    (pair_hi),
    .word_o  (pair_word),
    .vld_o   (pair_vld)
  );

  // Next-state logic: one state step per accepted byte, nothing on stalls.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (accept) begin
      case (state_q)
        HDR_HI: begin
          hi_we   = 1'b1;
          state_d = HDR_LO;
        end
        HDR_LO: begin
          cnt_d = pair_w;
          idx_d = '0;
          if (32'(pair_w) > 32'(MAX_WORDS)) begin
            state_d = ERR;
          end else if (pair_w == '0) begin
            state_d = POST_DATA;
          end else begin
            state_d = DAT_HI;
          end
        end
        DAT_HI: begin
          hi_we   = 1'b1;
          state_d = DAT_LO;
        end
        DAT_LO: begin
          lo_we = 1'b1;
`ifdef HACK_LOADER_CHECKSUM_EN
          sum_d = sum_q + pair_w;
`endif
          if (last_word) begin
            state_d = POST_DATA;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DAT_HI;
          end
        end
`ifdef HACK_LOADER_CHECKSUM_EN
        CHK_HI: begin
          hi_we   = 1'b1;
          state_d = CHK_LO;
        end
        CHK_LO: begin
          state_d = (pair_w == sum_q) ? RUN : ERR;
        end
`endif
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // FSM state, word index and header count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HDR_HI;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HACK_LOADER_CHECKSUM_EN
  // Running checksum of every word written this load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // Registered outputs: ready follows the state being entered, done lags RUN
  // by a cycle so the final ROM write never overlaps the CPU leaving reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (lo_we) begin
        addr_q <= idx_q;
      end
      ready_q <= is_loading(state_d);
      done_q  <= (state_q == RUN);
      err_q   <= (state_d == ERR);
    end
  end

  assign in_ready  = ready_q;
  assign rom_we    = pair_vld;
  assign rom_addr  = addr_q;
  assign rom_wdata = pair_word;
  assign cpu_nrst  = done_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hack_loader.sv
// tb_hack_loader: directed vector table for the loader plus hand-written
// sequences for stalls, mid-load reset and (optionally) the checksum.
module tb_hack_loader;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_nrst;
  logic        done;
  logic        err;

  int checks;
  int errors;
  int we_cnt;
  logic [14:0] last_addr;
  logic [15:0] last_data;

  hack_loader #(.ADDR_W(15), .MAX_WORDS(32768)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_nrst  (cpu_nrst),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record ROM writes away from the active edge.
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      we_cnt    = we_cnt + 1;
      last_addr = rom_addr;
      last_data = rom_wdata;
    end
  end

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wd;
    logic        nrst;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic rdy, input logic we, input logic [14:0] addr,
                     input logic [15:0] wd, input logic nrst, input logic dn,
                     input logic er);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.rdy = rdy; t.we = we; t.addr = addr;
    t.wd = wd; t.nrst = nrst; t.dn = dn; t.er = er;
    tbl.push_back(t);
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_out(input logic rdy, input logic we,
                                           input logic nrst, input logic dn,
                                           input logic er, input logic [14:0] a,
                                           input logic [15:0] w);
    return {28'd0, rdy, we, nrst, dn, er, a, w};
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    we_cnt   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // r  v  d       rdy we addr   wdata     nrst dn er
    // N=2, words 0x0003, 0xEC10, no stalls
    add(1, 0, 8'h00, 0, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h02, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h03, 1, 1, 15'd0, 16'h0003, 0, 0, 0);
    add(0, 1, 8'hEC, 1, 0, 15'd0, 16'h0003, 0, 0, 0);
    add(0, 1, 8'h10, 0, 1, 15'd1, 16'hEC10, 0, 0, 0);
    add(0, 1, 8'h55, 0, 0, 15'd1, 16'hEC10, 1, 1, 0);
    add(0, 0, 8'h00, 0, 0, 15'd1, 16'hEC10, 1, 1, 0);
    // N=0: straight to RUN, no writes
    add(1, 0, 8'h00, 0, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h00, 0, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 15'd0, 16'h0000, 1, 1, 0);
    add(0, 1, 8'h00, 0, 0, 15'd0, 16'h0000, 1, 1, 0);
    // header 0x8001 > MAX_WORDS: sticky error
    add(1, 0, 8'h00, 0, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h80, 1, 0, 15'd0, 16'h0000, 0, 0, 0);
    add(0, 1, 8'h01, 0, 0, 15'd0, 16'h0000, 0, 0, 1);
    add(0, 0, 8'h00, 0, 0, 15'd0, 16'h0000, 0, 0, 1);
    add(0, 1, 8'hAA, 0, 0, 15'd0, 16'h0000, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      chk($sformatf("row%0d", i),
          pack_out(in_ready, rom_we, cpu_nrst, done, err, rom_addr, rom_wdata),
          pack_out(tbl[i].rdy, tbl[i].we, tbl[i].nrst, tbl[i].dn, tbl[i].er,
                   tbl[i].addr, tbl[i].wd));
    end

    // N=1 with in_valid toggling every cycle; junk data on idle cycles
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    we_cnt = 0;
    step(0, 1, 8'h00); step(0, 0, 8'hFF);
    step(0, 1, 8'h01); step(0, 0, 8'hFF);
    step(0, 1, 8'hAB); step(0, 0, 8'hFF);
    chk("stall_nrst_before", {63'd0, cpu_nrst}, 64'd0);
    step(0, 1, 8'hCD); step(0, 0, 8'hFF);
    step(0, 0, 8'hFF);
    chk("stall_we_count", 64'(we_cnt), 64'd1);
    chk("stall_addr", {49'd0, last_addr}, 64'd0);
    chk("stall_data", {48'd0, last_data}, 64'h0000_ABCD);
    chk("stall_done", {62'd0, done, cpu_nrst}, 64'd3);
    chk("stall_ready", {63'd0, in_ready}, 64'd0);

    // Reset after 3 of 6 data bytes, then a fresh N=1 stream
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    we_cnt = 0;
    step(0, 1, 8'h00); step(0, 1, 8'h03);
    step(0, 1, 8'h11); step(0, 1, 8'h22); step(0, 1, 8'h33);
    step(1, 0, 8'h00);
    chk("abort_partial_writes", 64'(we_cnt), 64'd1);
    chk("abort_reset_outs", pack_out(in_ready, rom_we, cpu_nrst, done, err, rom_addr, rom_wdata),
        pack_out(0, 0, 0, 0, 0, 15'd0, 16'h0000));
    step(0, 0, 8'h00);
    we_cnt = 0;
    step(0, 1, 8'h00); step(0, 1, 8'h01);
    step(0, 1, 8'h12); step(0, 1, 8'h34);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("restart_we_count", 64'(we_cnt), 64'd1);
    chk("restart_word", {33'd0, last_addr, last_data}, {33'd0, 15'd0, 16'h1234});
    chk("restart_done", {61'd0, done, cpu_nrst, err}, 64'd6);

`ifdef HACK_LOADER_CHECKSUM_EN
    // Sum of 0x0001 + 0xFFFF wraps to 0x0000
    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    we_cnt = 0;
    step(0, 1, 8'h00); step(0, 1, 8'h02);
    step(0, 1, 8'h00); step(0, 1, 8'h01);
    step(0, 1, 8'hFF); step(0, 1, 8'hFF);
    step(0, 1, 8'h00); step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("cks_ok_writes", 64'(we_cnt), 64'd2);
    chk("cks_ok_state", {61'd0, done, cpu_nrst, err}, 64'd6);

    step(1, 0, 8'h00);
    step(0, 0, 8'h00);
    step(0, 1, 8'h00); step(0, 1, 8'h02);
    step(0, 1, 8'h00); step(0, 1, 8'h01);
    step(0, 1, 8'hFF); step(0, 1, 8'hFF);
    step(0, 1, 8'h00); step(0, 1, 8'h01);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    chk("cks_bad_state", {60'd0, in_ready, done, cpu_nrst, err}, 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
